// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into short-press, double-click, long-press,
// auto-repeat and hold indications; every output is a flop.
module key_event_decoder #(
  parameter int unsigned LONG_CNT   = 2_500_000,
  parameter int unsigned DBL_CNT    = 15_000_000,
  parameter int unsigned REPEAT_CNT = 5_000_000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_evt,
  output logic hold
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dbl_pend, dbl_pend_nxt;
  logic             short_nxt, dbl_nxt, long_nxt, rep_nxt, hold_nxt;
  logic             press_ev, rel_ev;

  assign press_ev = key_flag & ~key_state;
  assign rel_ev   = key_flag &  key_state;

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dbl_pend     <= 1'b0;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_evt   <= 1'b0;
      hold         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      dbl_pend     <= dbl_pend_nxt;
      short_press  <= short_nxt;
      double_click <= dbl_nxt;
      long_press   <= long_nxt;
      repeat_evt   <= rep_nxt;
      hold         <= hold_nxt;
    end
  end

  // Next state, counter and event decode; a flag always beats a same-cycle timeout.
  // A release-terminated double click is delayed one cycle through dbl_pend.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    dbl_pend_nxt = 1'b0;
    short_nxt    = 1'b0;
    dbl_nxt      = dbl_pend;
    long_nxt     = 1'b0;
    rep_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_ev) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (rel_ev) begin
          state_nxt = WAIT2;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_nxt = PRESS2;
        end else if (cnt == DBL_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESS2: begin
        if (rel_ev) begin
          state_nxt    = IDLE;
          dbl_pend_nxt = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = DRAIN;
          dbl_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (rel_ev) begin
          state_nxt = IDLE;
        end else if (cnt == REP_LAST) begin
          rep_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (rel_ev) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // hold covers the entry cycle and stays up through the releasing cycle
    hold_nxt = (state == LONG) || (state_nxt == LONG);
  end

endmodule
